// File: rtl/overheat_protection_ctrl.sv
// Multi-engine overheat protection: k-of-N sensor voting, persistence filter with
// hysteresis, auto/manual suppression, sticky emergency flag and saturating event counter.
module overheat_protection_ctrl #(
    parameter int NUM_ENGINES    = 2,
    parameter int NUM_SENSORS    = 3,
    parameter int VOTE_THRESHOLD = 2,
    parameter int PERSIST_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_ENGINES*NUM_SENSORS-1:0] sensors,
    input  logic                               auto_mode,
    input  logic [NUM_ENGINES-1:0]             manual_req,
    input  logic                               ack,
    output logic [NUM_ENGINES-1:0]             overheat,
    output logic [NUM_ENGINES-1:0]             suppress,
    output logic                               emergency,
    output logic [7:0]                         event_count
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_PENDING  = 2'd1,
        ST_OVERHEAT = 2'd2,
        ST_RECOVER  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] PERSIST  = CNT_W'(PERSIST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       VOTE_MIN = 4'(VOTE_THRESHOLD);

    function automatic logic [3:0] popcount(input logic [NUM_SENSORS-1:0] s);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            c = c + {3'b000, s[i]};
        end
        return c;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b00000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_e                  state_q [NUM_ENGINES];
    state_e                  state_d [NUM_ENGINES];
    logic [CNT_W-1:0]        cnt_q   [NUM_ENGINES];
    logic [CNT_W-1:0]        cnt_d   [NUM_ENGINES];
    logic [NUM_ENGINES-1:0]  vote;
    logic [NUM_ENGINES-1:0]  overheat_d;
    logic [NUM_ENGINES-1:0]  onset;
    logic [3:0]              onset_cnt;
    logic [CNT_W-1:0]        cnt_inc;

    logic [NUM_ENGINES-1:0]  overheat_q;
    logic [NUM_ENGINES-1:0]  suppress_q;
    logic                    emergency_q;
    logic [7:0]              event_count_q;

    always_comb begin
        for (int e = 0; e < NUM_ENGINES; e++) begin
            vote[e] = popcount(sensors[e*NUM_SENSORS +: NUM_SENSORS]) >= VOTE_MIN;
        end
    end

    // Per-engine persistence FSM; onset marks entry into OVERHEAT from NORMAL/PENDING only
    always_comb begin
        onset_cnt = 4'd0;
        cnt_inc   = '0;
        for (int e = 0; e < NUM_ENGINES; e++) begin
            state_d[e]    = state_q[e];
            cnt_d[e]      = cnt_q[e];
            onset[e]      = 1'b0;
            cnt_inc       = cnt_q[e] + CNT_ONE;
            unique case (state_q[e])
                ST_NORMAL: begin
                    if (vote[e]) begin
                        if (PERSIST_CYCLES == 1) begin
                            state_d[e] = ST_OVERHEAT;
                            cnt_d[e]   = '0;
                            onset[e]   = 1'b1;
                        end else begin
                            state_d[e] = ST_PENDING;
                            cnt_d[e]   = CNT_ONE;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!vote[e]) begin
                        state_d[e] = ST_NORMAL;
                        cnt_d[e]   = '0;
                    end else if (cnt_inc == PERSIST) begin
                        state_d[e] = ST_OVERHEAT;
                        cnt_d[e]   = '0;
                        onset[e]   = 1'b1;
                    end else begin
                        cnt_d[e]   = cnt_inc;
                    end
                end
                ST_OVERHEAT: begin
                    if (!vote[e]) begin
                        if (PERSIST_CYCLES == 1) begin
                            state_d[e] = ST_NORMAL;
                            cnt_d[e]   = '0;
                        end else begin
                            state_d[e] = ST_RECOVER;
                            cnt_d[e]   = CNT_ONE;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (vote[e]) begin
                        state_d[e] = ST_OVERHEAT;
                        cnt_d[e]   = '0;
                    end else if (cnt_inc == PERSIST) begin
                        state_d[e] = ST_NORMAL;
                        cnt_d[e]   = '0;
                    end else begin
                        cnt_d[e]   = cnt_inc;
                    end
                end
                default: begin
                    state_d[e] = ST_NORMAL;
                    cnt_d[e]   = '0;
                end
            endcase
            overheat_d[e] = (state_d[e] == ST_OVERHEAT) || (state_d[e] == ST_RECOVER);
            onset_cnt     = onset_cnt + {3'b000, onset[e]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENGINES; e++) begin
                state_q[e] <= ST_NORMAL;
                cnt_q[e]   <= '0;
            end
            overheat_q    <= '0;
            suppress_q    <= '0;
            emergency_q   <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            for (int e = 0; e < NUM_ENGINES; e++) begin
                state_q[e] <= state_d[e];
                cnt_q[e]   <= cnt_d[e];
            end
            overheat_q    <= overheat_d;
            suppress_q    <= auto_mode ? overheat_d : manual_req;
            // Set dominates ack; ack only clears once every engine is clear
            if (|overheat_d) begin
                emergency_q <= 1'b1;
            end else if (ack) begin
                emergency_q <= 1'b0;
            end
            event_count_q <= sat_add(event_count_q, onset_cnt);
        end
    end

    assign overheat    = overheat_q;
    assign suppress    = suppress_q;
    assign emergency   = emergency_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_overheat_protection_ctrl.sv
// Bench for overheat_protection_ctrl: directed scenarios plus random bursts, two builds
// (vote threshold 2 and 1) checked every cycle against a run-length reference model.
module tb_overheat_protection_ctrl;

    localparam int NE = 2;
    localparam int NS = 3;
    localparam int P  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NE*NS-1:0] sensors;
    logic            auto_mode;
    logic [NE-1:0]   manual_req;
    logic            ack;

    logic [NE-1:0] ovh_a, sup_a, ovh_b, sup_b;
    logic          em_a, em_b;
    logic [7:0]    ec_a, ec_b;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state, index 0 = threshold 2 build, 1 = threshold 1 build
    bit m_ovh [2][NE];
    int m_run [2][NE];
    bit m_sup [2][NE];
    bit m_em  [2];
    int m_ec  [2];

    always #5 clk = ~clk;

    overheat_protection_ctrl #(
        .NUM_ENGINES(NE), .NUM_SENSORS(NS), .VOTE_THRESHOLD(2), .PERSIST_CYCLES(P), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .sensors(sensors), .auto_mode(auto_mode),
        .manual_req(manual_req), .ack(ack), .overheat(ovh_a), .suppress(sup_a),
        .emergency(em_a), .event_count(ec_a)
    );

    overheat_protection_ctrl #(
        .NUM_ENGINES(NE), .NUM_SENSORS(NS), .VOTE_THRESHOLD(1), .PERSIST_CYCLES(P), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .sensors(sensors), .auto_mode(auto_mode),
        .manual_req(manual_req), .ack(ack), .overheat(ovh_b), .suppress(sup_b),
        .emergency(em_b), .event_count(ec_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Overheat confirms after P consecutive true votes and clears after P consecutive false ones.
    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            int th;
            bit any;
            int on;
            th  = (c == 0) ? 2 : 1;
            any = 0;
            on  = 0;
            if (rst) begin
                for (int e = 0; e < NE; e++) begin
                    m_ovh[c][e] = 0;
                    m_run[c][e] = 0;
                    m_sup[c][e] = 0;
                end
                m_em[c] = 0;
                m_ec[c] = 0;
            end else begin
                for (int e = 0; e < NE; e++) begin
                    int hot;
                    bit v;
                    hot = 0;
                    for (int s = 0; s < NS; s++) hot += int'(sensors[e*NS+s]);
                    v = (hot >= th);
                    if (v != m_ovh[c][e]) m_run[c][e]++;
                    else m_run[c][e] = 0;
                    if (m_run[c][e] == P) begin
                        if (!m_ovh[c][e]) on++;
                        m_ovh[c][e] = v;
                        m_run[c][e] = 0;
                    end
                    m_sup[c][e] = auto_mode ? m_ovh[c][e] : manual_req[e];
                    any |= m_ovh[c][e];
                end
                if (any) m_em[c] = 1;
                else if (ack) m_em[c] = 0;
                m_ec[c] = (m_ec[c] + on > 255) ? 255 : m_ec[c] + on;
            end
        end
    endtask

    task automatic check_all();
        logic [NE-1:0] eo0, es0, eo1, es1;
        for (int e = 0; e < NE; e++) begin
            eo0[e] = m_ovh[0][e];
            es0[e] = m_sup[0][e];
            eo1[e] = m_ovh[1][e];
            es1[e] = m_sup[1][e];
        end
        check("overheat_t2",  32'(ovh_a), 32'(eo0));
        check("suppress_t2",  32'(sup_a), 32'(es0));
        check("emergency_t2", 32'(em_a),  32'(m_em[0]));
        check("events_t2",    32'(ec_a),  32'(m_ec[0]));
        check("overheat_t1",  32'(ovh_b), 32'(eo1));
        check("suppress_t1",  32'(sup_b), 32'(es1));
        check("emergency_t1", 32'(em_b),  32'(m_em[1]));
        check("events_t1",    32'(ec_b),  32'(m_ec[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        sensors    = '0;
        auto_mode  = 1'b1;
        manual_req = '0;
        ack        = 1'b0;
        steps(2);
        check("reset_overheat", 32'(ovh_a), 32'd0);
        check("reset_events",   32'(ec_a),  32'd0);
        rst = 1'b0;

        // Defaults: engine0 two of three hot, confirmed on the 4th sample
        sensors = 6'b000_011;
        steps(3);
        check("pre_confirm_overheat", 32'(ovh_a), 32'd0);
        step();
        check("confirm_overheat",  32'(ovh_a), 32'b01);
        check("confirm_suppress",  32'(sup_a), 32'b01);
        check("confirm_emergency", 32'(em_a),  32'd1);
        check("confirm_events",    32'(ec_a),  32'd1);

        // Glitch filter on engine1
        sensors = '0;
        do_reset();
        sensors = 6'b110_000;
        steps(3);
        sensors = '0;
        step();
        check("glitch_overheat", 32'(ovh_a), 32'd0);
        check("glitch_events",   32'(ec_a),  32'd0);
        sensors = 6'b110_000;
        steps(4);
        check("hold_overheat", 32'(ovh_a), 32'b10);

        // Single stuck sensor: only the threshold-1 build reacts
        sensors = '0;
        do_reset();
        sensors = 6'b000_001;
        steps(3);
        check("stuck_t1_pre", 32'(ovh_b), 32'd0);
        step();
        check("stuck_t1_overheat", 32'(ovh_b), 32'b01);
        steps(96);
        check("stuck_t2_overheat", 32'(ovh_a), 32'd0);

        // Manual mode, then back to auto
        sensors = '0;
        do_reset();
        auto_mode  = 1'b0;
        manual_req = 2'b10;
        sensors    = 6'b000_011;
        steps(4);
        check("manual_overheat",  32'(ovh_a), 32'b01);
        check("manual_suppress",  32'(sup_a), 32'b10);
        check("manual_emergency", 32'(em_a),  32'd1);
        auto_mode = 1'b1;
        step();
        check("auto_suppress", 32'(sup_a), 32'b01);

        // Recovery with hysteresis and acknowledge
        ack = 1'b1;
        step();
        check("ack_ignored", 32'(em_a), 32'd1);
        ack     = 1'b0;
        sensors = '0;
        steps(3);
        check("recover_hold", 32'(ovh_a), 32'b01);
        sensors = 6'b000_011;
        step();
        check("reentry_overheat", 32'(ovh_a), 32'b01);
        check("reentry_events",   32'(ec_a),  32'd1);
        sensors = '0;
        steps(3);
        check("recover_hold2", 32'(ovh_a), 32'b01);
        step();
        check("recover_drop", 32'(ovh_a), 32'd0);
        check("em_sticky",    32'(em_a),  32'd1);
        ack = 1'b1;
        step();
        check("ack_clears", 32'(em_a), 32'd0);
        ack = 1'b0;

        // Reset discards partial persistence
        sensors = 6'b000_011;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(3);
        check("post_reset_pre", 32'(ovh_a), 32'd0);
        step();
        check("post_reset_confirm", 32'(ovh_a), 32'b01);

        // Saturation of the event counter
        sensors = '0;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            sensors = 6'b000_011;
            steps(P);
            sensors = '0;
            steps(P);
        end
        check("saturate_t2", 32'(ec_a), 32'd255);
        check("saturate_t1", 32'(ec_b), 32'd255);

        // Random bursts of held sensor patterns
        do_reset();
        for (int b = 0; b < 300; b++) begin
            int hold;
            sensors    = 6'($urandom);
            auto_mode  = 1'($urandom);
            manual_req = 2'($urandom);
            rst        = ($urandom_range(0, 40) == 0);
            hold       = $urandom_range(1, 7);
            for (int i = 0; i < hold; i++) begin
                ack = ($urandom_range(0, 3) == 0);
                step();
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
